// File: rtl/pea_pkg.sv
// Shared types and helpers for the PEA processing elements.
// - acc_op_e     : per-lane accumulation operation
// - vec_mode_e   : lane partitioning of the datapath word
// - vacc_state_e : run state of the accumulating PE
// - norm_mode / lane_width / reduce_levels : lane-geometry helpers
package pea_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MAC = 2'b10,
    OP_MAX = 2'b11
  } acc_op_e;

  typedef enum logic [1:0] {
    VM_FULL = 2'b00,
    VM_V8   = 2'b01,
    VM_V16  = 2'b10,
    VM_RSVD = 2'b11
  } vec_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACC    = 2'b01,
    ST_REDUCE = 2'b10,
    ST_OUT    = 2'b11
  } vacc_state_e;

  // The reserved encoding behaves exactly like full-word mode.
  function automatic vec_mode_e norm_mode(logic [1:0] m);
    return (m == 2'b11) ? VM_FULL : vec_mode_e'(m);
  endfunction

  function automatic int unsigned lane_width(vec_mode_e m, int unsigned n_bits);
    case (m)
      VM_V8:   return 8;
      VM_V16:  return 16;
      default: return n_bits;
    endcase
  endfunction

  // Number of pairwise reduction levels needed to fold all lanes into one.
  function automatic int unsigned reduce_levels(vec_mode_e m, int unsigned n_bits);
    return $clog2(n_bits / lane_width(m, n_bits));
  endfunction

endpackage

// File: rtl/lane_reduce_stage.sv
// One level of the cross-lane reduction tree (purely combinational).
// Adjacent input lanes (2p, 2p+1) are sign-extended to twice their width and
// either summed or signed-maxed into output lane p. The output bus has the
// same total width as the input, holding N_IN/2 lanes of 2*IN_W bits.
// Ports:
// - din    : N_IN lanes of IN_W bits
// - is_max : 1 = signed max, 0 = sum
// - dout   : N_IN/2 lanes of 2*IN_W bits
module lane_reduce_stage #(
  parameter int unsigned IN_W = 8,
  parameter int unsigned N_IN = 4
) (
  input  logic [IN_W*N_IN-1:0] din,
  input  logic                 is_max,
  output logic [IN_W*N_IN-1:0] dout
);

  localparam int unsigned OUT_W = 2 * IN_W;

  for (genvar p = 0; p < N_IN / 2; p++) begin : g_pair
    logic [IN_W-1:0]         lo_raw;
    logic [IN_W-1:0]         hi_raw;
    logic signed [OUT_W-1:0] lo;
    logic signed [OUT_W-1:0] hi;

    assign lo_raw = din[(2*p)*IN_W +: IN_W];
    assign hi_raw = din[(2*p+1)*IN_W +: IN_W];
    // Doubling the width before combining means the sum can never wrap.
    assign lo = {{IN_W{lo_raw[IN_W-1]}}, lo_raw};
    assign hi = {{IN_W{hi_raw[IN_W-1]}}, hi_raw};

    assign dout[p*OUT_W +: OUT_W] = is_max ? ((hi > lo) ? hi : lo) : (lo + hi);
  end

endmodule

// File: rtl/dae_vacc_pe.sv
// Accumulating PE for the DAE-mode PEA.
// A run is launched by start_i (config latched), then acc_len_i operand beats
// are accumulated per lane (8/16/N_BITS-bit lanes; ADD, SUB, MAC, MAX), the
// lanes are folded pairwise over registered reduction levels, and the
// sign-extended N_BITS result is presented with a valid/ready handshake.
// Ports:
// - clk_i, rst_i              : clock, synchronous active-high reset
// - pe_op_i                   : N_INPUTS candidate operands
// - mux_a_sel_i, mux_b_sel_i  : operand A/B source select (latched at start)
// - acc_op_i, vec_mode_i      : operation and lane mode (latched at start)
// - acc_len_i                 : beats per run (latched at start)
// - start_i                   : begin a run
// - op_valid_i / op_ready_o   : operand beat handshake
// - busy_o                    : run in progress
// - res_o / res_valid_o / res_ready_i : result handshake
module dae_vacc_pe
  import pea_pkg::*;
#(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned ACC_CNT_W = 16,
  localparam int unsigned SEL_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_INPUTS-1:0][N_BITS-1:0]  pe_op_i,
  input  logic [SEL_W-1:0]                 mux_a_sel_i,
  input  logic [SEL_W-1:0]                 mux_b_sel_i,
  input  logic [1:0]                       acc_op_i,
  input  logic [1:0]                       vec_mode_i,
  input  logic [ACC_CNT_W-1:0]             acc_len_i,
  input  logic                             start_i,
  input  logic                             op_valid_i,
  output logic                             op_ready_o,
  output logic                             busy_o,
  output logic [N_BITS-1:0]                res_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i
);

  // Reduction levels for the narrowest (8-bit) lanes; 16-bit lanes enter the
  // tree one level in and full-word runs skip it entirely.
  localparam int unsigned NLVL  = $clog2(N_BITS / 8);
  localparam int unsigned LVL_W = $clog2(NLVL + 1);
  localparam int unsigned NSEL  = 2 ** LVL_W;

  vacc_state_e            state_q;
  acc_op_e                op_q;
  vec_mode_e              mode_q;
  logic [SEL_W-1:0]       sel_a_q, sel_b_q;
  logic [ACC_CNT_W-1:0]   len_q, count_q;
  logic [N_BITS-1:0]      acc_q, red_q, res_q;
  logic                   red_started_q;
  logic [LVL_W-1:0]       lvl_q;
  logic                   res_valid_q;

  // ---------------------------------------------------------------------------
  // Start decode and initial accumulator value
  // ---------------------------------------------------------------------------
  vec_mode_e         start_mode;
  acc_op_e           start_op;
  logic [LVL_W-1:0]  start_lvl;
  logic              do_start;
  int unsigned       init_lw;
  logic [N_BITS-1:0] init_val;

  assign start_mode = norm_mode(vec_mode_i);
  assign start_op   = acc_op_e'(acc_op_i);
  assign start_lvl  = LVL_W'(NLVL - reduce_levels(start_mode, N_BITS));
  // A new run may begin from IDLE or in the same cycle a result is consumed.
  assign do_start   = start_i &&
                      ((state_q == ST_IDLE) || ((state_q == ST_OUT) && res_ready_i));

  // MAX starts every lane at its most-negative value (only the lane MSB set).
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    init_lw  = lane_width(start_mode, N_BITS);
    init_val = '0;
    if (start_op == OP_MAX) begin
      for (int i = 0; i < int'(N_BITS); i++) begin
        if (((i + 1) % init_lw) == 0) init_val[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane-partitioned ALU: one result per lane width, selected by the run mode
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0]         op_a, op_b, alu_res;
  logic [2:0][N_BITS-1:0]    alu_w;

  assign op_a = pe_op_i[sel_a_q];
  assign op_b = pe_op_i[sel_b_q];

  for (genvar g = 0; g < 3; g++) begin : g_width
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 16 : N_BITS;
    for (genvar l = 0; l < N_BITS / W; l++) begin : g_lane
      logic [W-1:0] a_l, b_l, c_l, p_l, r_l;

      assign a_l = op_a[l*W +: W];
      assign b_l = op_b[l*W +: W];
      assign c_l = acc_q[l*W +: W];
      // Low W bits of the product are identical for signed and unsigned.
      assign p_l = a_l * b_l;

      always_comb begin
        r_l = c_l;
        case (op_q)
          OP_ADD: r_l = c_l + a_l;
          OP_SUB: r_l = c_l - a_l;
          OP_MAC: r_l = c_l + p_l;
          OP_MAX: r_l = ($signed(a_l) > $signed(c_l)) ? a_l : c_l;
          default: r_l = c_l;
        endcase
      end

      assign alu_w[g][l*W +: W] = r_l;
    end
  end

  always_comb begin
    case (mode_q)
      VM_V8:   alu_res = alu_w[0];
      VM_V16:  alu_res = alu_w[1];
      default: alu_res = alu_w[2];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reduction tree: one combinational stage per level, one shared level register
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0] red_src;
  logic [N_BITS-1:0] stage_sel [NSEL];
  logic              red_is_max;

  // The first level reads the accumulator; later levels read the level register.
  assign red_src    = red_started_q ? red_q : acc_q;
  assign red_is_max = (op_q == OP_MAX);

  for (genvar k = 0; k < int'(NSEL); k++) begin : g_level
    if (k < int'(NLVL)) begin : g_stage
      lane_reduce_stage #(
        .IN_W (8 << k),
        .N_IN (N_BITS / (8 << k))
      ) u_stage (
        .din    (red_src),
        .is_max (red_is_max),
        .dout   (stage_sel[k])
      );
    end else begin : g_pass
      assign stage_sel[k] = red_src;
    end
  end

  // ---------------------------------------------------------------------------
  // Run control
  // ---------------------------------------------------------------------------
  logic last_beat;
  assign last_beat = (count_q == len_q - ACC_CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      mode_q        <= VM_FULL;
      sel_a_q       <= '0;
      sel_b_q       <= '0;
      len_q         <= '0;
      count_q       <= '0;
      acc_q         <= '0;
      red_q         <= '0;
      red_started_q <= 1'b0;
      lvl_q         <= '0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
    end else if (do_start) begin
      op_q          <= start_op;
      mode_q        <= start_mode;
      sel_a_q       <= mux_a_sel_i;
      sel_b_q       <= mux_b_sel_i;
      len_q         <= acc_len_i;
      count_q       <= '0;
      acc_q         <= init_val;
      red_started_q <= 1'b0;
      lvl_q         <= start_lvl;
      res_valid_q   <= 1'b0;
      state_q       <= (acc_len_i == '0) ? ST_REDUCE : ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (op_valid_i) begin
            acc_q   <= alu_res;
            count_q <= count_q + ACC_CNT_W'(1);
            if (last_beat) state_q <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          // Once every level has been applied, the word is already N_BITS wide
          // and sign-extended, so it goes straight to the output register.
          if (lvl_q == LVL_W'(NLVL)) begin
            res_q       <= red_src;
            res_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            red_q         <= stage_sel[lvl_q];
            red_started_q <= 1'b1;
            lvl_q         <= lvl_q + LVL_W'(1);
          end
        end
        ST_OUT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready_o  = (state_q == ST_ACC);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;

endmodule
